// File: rtl/counter_seq_pkg.sv
// Shared state encoding for the counter run-control sequencer.
package counter_seq_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10,
    ST_DONE = 2'b11
  } state_t;

endpackage

// File: rtl/counter_sequencer_core.sv
// Up-counter with synchronous clear, load-to-zero and count enable.
module counter_core #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         load_zero,
  input  logic         enable,
  output logic [W-1:0] cnt
);

  // Count register: clear and load-zero both win over enable.
  always_ff @(posedge clock) begin
    if (clear) begin
      cnt <= {W{1'b0}};
    end else if (load_zero) begin
      cnt <= {W{1'b0}};
    end else if (enable) begin
      cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Run-control sequencer: start/stop/pause, prescaled counting, one-shot or periodic runs.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  input  logic                  periodic,
  input  logic [WIDTH-1:0]      terminal,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      counterOut,
  output logic                  busy,
  output logic                  done
);

  state_t                state_r;
  logic [WIDTH-1:0]      term_r;
  logic [PRESCALE_W-1:0] prescale_r;
  logic                  periodic_r;
  logic                  done_r;
  logic                  busy_r;

  logic [PRESCALE_W-1:0] presc_cnt_s;
  logic                  tick_s;
  logic                  at_term_s;
  logic                  main_load_s;
  logic                  main_en_s;
  logic                  presc_load_s;
  logic                  presc_en_s;

  // Tick and counter control decode; stop and start dominate any tick.
  always_comb begin
    tick_s       = 1'b0;
    at_term_s    = 1'b0;
    main_load_s  = 1'b0;
    main_en_s    = 1'b0;
    presc_load_s = 1'b0;
    presc_en_s   = 1'b0;
    at_term_s    = (counterOut == term_r);
    tick_s       = (state_r == ST_RUN) && !pause && (presc_cnt_s == prescale_r);
    if (stop || start) begin
      main_load_s  = 1'b1;
      presc_load_s = 1'b1;
    end else begin
      main_load_s  = tick_s && at_term_s && periodic_r;
      main_en_s    = tick_s && !at_term_s;
      presc_load_s = tick_s;
      presc_en_s   = (state_r == ST_RUN) && !pause;
    end
  end

  counter_core #(.W(WIDTH)) u_main (
    .clock     (clock),
    .clear     (clear),
    .load_zero (main_load_s),
    .enable    (main_en_s),
    .cnt       (counterOut)
  );

  counter_core #(.W(PRESCALE_W)) u_presc (
    .clock     (clock),
    .clear     (clear),
    .load_zero (presc_load_s),
    .enable    (presc_en_s),
    .cnt       (presc_cnt_s)
  );

  // Sequencer FSM with capture registers; busy tracks the state being entered.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_r    <= ST_IDLE;
      term_r     <= {WIDTH{1'b0}};
      prescale_r <= {PRESCALE_W{1'b0}};
      periodic_r <= 1'b0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else if (stop) begin
      state_r <= ST_IDLE;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else if (start) begin
      state_r    <= ST_RUN;
      term_r     <= terminal;
      prescale_r <= prescale;
      periodic_r <= periodic;
      done_r     <= 1'b0;
      busy_r     <= 1'b1;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_RUN: begin
          if (pause) begin
            state_r <= ST_HOLD;
          end else if (tick_s && at_term_s) begin
            done_r <= 1'b1;
            if (!periodic_r) begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
            end else begin
              state_r <= ST_RUN;
            end
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_HOLD: begin
          if (!pause) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_HOLD;
          end
        end
        ST_IDLE: state_r <= ST_IDLE;
        ST_DONE: state_r <= ST_DONE;
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;

endmodule
